// File: rtl/cl_vled_pattern_gen.sv
// Virtual-LED pattern generator fed by the OCL register-decode stage.
// Owns CTRL/PATTERN/PERIOD/STEPS and steps vled_out through the selected pattern.
module cl_vled_pattern_gen #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0600,
    parameter logic [31:0] UNIMPL_VALUE = 32'hDEAD_BEEF
) (
    input  logic        clk_main_a0,
    input  logic        rst_main_n,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    input  logic        rd_en,
    input  logic [31:0] rd_addr,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [15:0] vled_out
);
    localparam logic [31:0] CTRL_ADDR = BASE_ADDR;
    localparam logic [31:0] PAT_ADDR  = BASE_ADDR + 32'h4;
    localparam logic [31:0] PER_ADDR  = BASE_ADDR + 32'h8;
    localparam logic [31:0] STEP_ADDR = BASE_ADDR + 32'hC;

    typedef enum logic [1:0] {
        MODE_STATIC   = 2'd0,
        MODE_BLINK    = 2'd1,
        MODE_ROTATE   = 2'd2,
        MODE_PINGPONG = 2'd3
    } mode_e;

    logic        ctrl_en;
    mode_e       ctrl_mode;
    logic [15:0] pattern;
    logic [23:0] period;
    logic [31:0] steps;
    logic [23:0] cnt;
    logic        reload_pending;
    logic        phase;
    logic        dir_right;
    logic        wr_ctrl;
    logic        wr_pat;
    logic        wr_per;
    logic        wr_hit;
    logic        do_reload;
    logic        tick;
    logic [31:0] rd_mux;

    assign wr_ctrl   = wr_en && (wr_addr == CTRL_ADDR);
    assign wr_pat    = wr_en && (wr_addr == PAT_ADDR);
    assign wr_per    = wr_en && (wr_addr == PER_ADDR);
    assign wr_hit    = wr_ctrl || wr_pat || wr_per;
    // A write in the reload cycle defers the reload until the burst ends.
    assign do_reload = reload_pending && !wr_hit;
    assign tick      = ctrl_en && (cnt == period) && !wr_hit && !reload_pending;

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= MODE_STATIC;
            pattern   <= '0;
            period    <= '0;
        end else begin
            if (wr_ctrl && wr_strb[0]) begin
                ctrl_en   <= wr_data[0];
                ctrl_mode <= mode_e'(wr_data[2:1]);
            end
            for (int b = 0; b < 2; b++) begin
                if (wr_pat && wr_strb[b]) pattern[8*b +: 8] <= wr_data[8*b +: 8];
            end
            for (int b = 0; b < 3; b++) begin
                if (wr_per && wr_strb[b]) period[8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            cnt            <= '0;
            steps          <= '0;
            reload_pending <= 1'b0;
            phase          <= 1'b0;
            dir_right      <= 1'b0;
            vled_out       <= '0;
        end else begin
            reload_pending <= wr_hit;
            if (!ctrl_en || do_reload || cnt == period) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 24'd1;
            end
            if (tick) steps <= steps + 32'd1;
            if (do_reload) begin
                phase     <= 1'b1;
                dir_right <= 1'b0;
                vled_out  <= (ctrl_mode == MODE_PINGPONG) ? 16'h0001 : pattern;
            end else if (tick) begin
                unique case (ctrl_mode)
                    MODE_STATIC: vled_out <= vled_out;
                    MODE_BLINK: begin
                        phase    <= ~phase;
                        vled_out <= phase ? 16'h0000 : pattern;
                    end
                    MODE_ROTATE: vled_out <= {vled_out[14:0], vled_out[15]};
                    MODE_PINGPONG: begin
                        if (!dir_right) begin
                            if (vled_out[15]) begin
                                dir_right <= 1'b1;
                                vled_out  <= vled_out >> 1;
                            end else begin
                                vled_out <= vled_out << 1;
                            end
                        end else begin
                            if (vled_out[0]) begin
                                dir_right <= 1'b0;
                                vled_out  <= vled_out << 1;
                            end else begin
                                vled_out <= vled_out >> 1;
                            end
                        end
                    end
                endcase
            end
            if (!ctrl_en) vled_out <= '0;
        end
    end

    always_comb begin
        rd_mux = UNIMPL_VALUE;
        unique case (1'b1)
            (rd_addr == CTRL_ADDR): rd_mux = {29'd0, ctrl_mode, ctrl_en};
            (rd_addr == PAT_ADDR):  rd_mux = {16'd0, pattern};
            (rd_addr == PER_ADDR):  rd_mux = {8'd0, period};
            (rd_addr == STEP_ADDR): rd_mux = steps;
            default:                rd_mux = UNIMPL_VALUE;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            rd_data  <= rd_en ? rd_mux : 32'd0;
        end
    end
endmodule

// File: tb/tb_cl_vled_pattern_gen.sv
// Bench for cl_vled_pattern_gen: directed scenarios plus random traffic
// checked against a tick-count reference model.
module tb_cl_vled_pattern_gen;
    localparam logic [31:0] BASE = 32'h0000_0600;

    logic        clk_main_a0 = 1'b0;
    logic        rst_main_n  = 1'b0;
    logic        wr_en       = 1'b0;
    logic [31:0] wr_addr     = '0;
    logic [31:0] wr_data     = '0;
    logic [3:0]  wr_strb     = '0;
    logic        rd_en       = 1'b0;
    logic [31:0] rd_addr     = '0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [15:0] vled_out;

    int total = 0;
    int bad   = 0;

    cl_vled_pattern_gen dut (
        .clk_main_a0(clk_main_a0),
        .rst_main_n (rst_main_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_strb    (wr_strb),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .vled_out   (vled_out)
    );

    always #5 clk_main_a0 = ~clk_main_a0;

    // Reference model: pattern value is a pure function of ticks since reload.
    int          cyc = 0;
    logic        m_en;
    logic [1:0]  m_mode;
    logic [15:0] m_pat;
    logic [23:0] m_per;
    logic [31:0] m_base;
    bit          m_pending;
    bit          m_running;
    int          m_rel;

    function automatic int m_ticks(input int e);
        if (!m_running) return 0;
        return (e - m_rel) / (int'(m_per) + 1);
    endfunction

    function automatic logic [31:0] m_steps();
        return m_base + 32'(m_ticks(cyc));
    endfunction

    function automatic logic [15:0] m_vled();
        int          k;
        int          p;
        logic [31:0] dbl;
        logic [15:0] one;
        if (!m_en) return 16'h0;
        k = m_ticks(cyc);
        case (m_mode)
            2'd0: return m_pat;
            2'd1: return (k % 2 == 0) ? m_pat : 16'h0;
            2'd2: begin
                dbl = {m_pat, m_pat} << (k % 16);
                return dbl[31:16];
            end
            default: begin
                p   = k % 30;
                one = 16'h1;
                return one << ((p <= 15) ? p : 30 - p);
            end
        endcase
    endfunction

    function automatic logic [31:0] m_reg(input logic [31:0] a);
        if (a == BASE)         return {29'd0, m_mode, m_en};
        if (a == BASE + 32'h4) return {16'd0, m_pat};
        if (a == BASE + 32'h8) return {8'd0, m_per};
        if (a == BASE + 32'hC) return m_steps();
        return 32'hDEAD_BEEF;
    endfunction

    task automatic model_reset();
        m_en = 0; m_mode = 0; m_pat = 0; m_per = 0; m_base = 0;
        m_pending = 0; m_running = 0; m_rel = 0;
    endtask

    task automatic model_edge();
        bit hit;
        cyc++;
        if (!rst_main_n) return;
        hit = wr_en && (wr_addr == BASE || wr_addr == BASE + 32'h4
                        || wr_addr == BASE + 32'h8);
        if (hit) begin
            if (m_running) m_base += 32'(m_ticks(cyc - 1));
            m_running = 0;
            if (wr_addr == BASE && wr_strb[0]) begin
                m_en   = wr_data[0];
                m_mode = wr_data[2:1];
            end
            if (wr_addr == BASE + 32'h4) begin
                if (wr_strb[0]) m_pat[7:0]  = wr_data[7:0];
                if (wr_strb[1]) m_pat[15:8] = wr_data[15:8];
            end
            if (wr_addr == BASE + 32'h8) begin
                if (wr_strb[0]) m_per[7:0]   = wr_data[7:0];
                if (wr_strb[1]) m_per[15:8]  = wr_data[15:8];
                if (wr_strb[2]) m_per[23:16] = wr_data[23:16];
            end
            m_pending = 1;
        end else if (m_pending) begin
            m_pending = 0;
            m_rel     = cyc;
            m_running = m_en;
        end
    endtask

    task automatic step();
        @(posedge clk_main_a0);
        model_edge();
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        step();
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] expd);
        expd  = m_reg(a);
        rd_en = 1'b1; rd_addr = a;
        step();
    endtask

    task automatic test_reset();
        logic [31:0] e;
        logic [31:0] addrs [5];
        addrs = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC, BASE + 32'h10};
        rst_main_n = 1'b0;
        model_reset();
        #20;
        total++;
        if (vled_out !== 16'h0) begin
            bad++; $display("FAIL reset_vled got=%h want=0000", vled_out);
        end
        total++;
        if ({rd_valid, rd_data} !== 33'h0) begin
            bad++; $display("FAIL reset_rd got=%b/%h want=0/0", rd_valid, rd_data);
        end
        @(negedge clk_main_a0);
        rst_main_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd(addrs[i], e);
            if (i == 4) e = 32'hDEAD_BEEF;
            else e = 32'h0;
            total++;
            if ({rd_valid, rd_data} !== {1'b1, e}) begin
                bad++;
                $display("FAIL reset_read[%0d] got=%b/%h want=1/%h", i, rd_valid, rd_data, e);
            end
            step();
            total++;
            if ({rd_valid, rd_data} !== 33'h0) begin
                bad++;
                $display("FAIL rd_idle[%0d] got=%b/%h want=0/0", i, rd_valid, rd_data);
            end
        end
    endtask

    task automatic test_static();
        logic [15:0] pat;
        logic [31:0] e;
        pat = 16'(($urandom % 16'hFFFF) + 1);
        wr(BASE + 32'h8, 32'd3, 4'hF);
        wr(BASE + 32'h4, {16'h0, pat}, 4'hF);
        wr(BASE, 32'h1, 4'h1);
        step();
        total++;
        if (vled_out !== pat) begin
            bad++; $display("FAIL static_reload got=%h want=%h", vled_out, pat);
        end
        for (int i = 0; i < 16; i++) begin
            step();
            total++;
            if (vled_out !== pat) begin
                bad++; $display("FAIL static_hold[%0d] got=%h want=%h", i, vled_out, pat);
            end
        end
        rd(BASE + 32'hC, e);
        total++;
        if (rd_data !== 32'd4 || e !== 32'd4) begin
            bad++; $display("FAIL static_steps got=%0d want=4 (model %0d)", rd_data, e);
        end
    endtask

    task automatic test_blink();
        logic [15:0] pat;
        pat = 16'(($urandom % 16'hFFFF) + 1);
        wr(BASE + 32'h8, 32'd2, 4'hF);
        wr(BASE + 32'h4, {16'h0, pat}, 4'h3);
        wr(BASE, 32'h3, 4'h1);
        for (int i = 0; i < 19; i++) begin
            step();
            total++;
            if (vled_out !== m_vled()) begin
                bad++; $display("FAIL blink[%0d] got=%h want=%h", i, vled_out, m_vled());
            end
        end
    endtask

    task automatic test_rotate();
        logic [15:0] want [3];
        want = '{16'h8001, 16'h0003, 16'h0006};
        wr(BASE + 32'h4, 32'h8001, 4'hF);
        wr(BASE + 32'h8, 32'h0, 4'hF);
        wr(BASE, 32'h5, 4'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (vled_out !== want[i]) begin
                bad++; $display("FAIL rotate_wrap[%0d] got=%h want=%h", i, vled_out, want[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (vled_out !== m_vled()) begin
                bad++; $display("FAIL rotate[%0d] got=%h want=%h", i, vled_out, m_vled());
            end
        end
        wr(BASE, 32'h0, 4'h1);
        step();
        total++;
        if (vled_out !== 16'h0) begin
            bad++; $display("FAIL rotate_disable got=%h want=0000", vled_out);
        end
    endtask

    task automatic test_pingpong();
        wr(BASE + 32'h8, 32'h0, 4'hF);
        wr(BASE, 32'h7, 4'h1);
        step();
        total++;
        if (vled_out !== 16'h0001) begin
            bad++; $display("FAIL pp_reload got=%h want=0001", vled_out);
        end
        for (int j = 1; j <= 35; j++) begin
            step();
            total++;
            if (vled_out !== m_vled()) begin
                bad++; $display("FAIL pp[%0d] got=%h want=%h", j, vled_out, m_vled());
            end
            if (j == 15 || j == 16 || j == 30) begin
                total++;
                if (vled_out !== (j == 15 ? 16'h8000 : j == 16 ? 16'h4000 : 16'h0001)) begin
                    bad++; $display("FAIL pp_edge[%0d] got=%h", j, vled_out);
                end
            end
        end
    endtask

    task automatic test_collision();
        logic [15:0] pat;
        logic [31:0] exp_s;
        logic [31:0] e;
        int          newp;
        int          guard;
        pat  = 16'(($urandom % 16'hFFFE) + 1);
        newp = int'($urandom_range(1, 4));
        wr(BASE + 32'h4, {16'h0, pat}, 4'hF);
        wr(BASE + 32'h8, 32'd3, 4'hF);
        wr(BASE, 32'h5, 4'h1);
        step();
        repeat (5) step();
        guard = 0;
        while (((cyc + 1 - m_rel) % 4) != 0 && guard < 8) begin
            step();
            guard++;
        end
        total++;
        if (guard >= 8) begin
            bad++; $display("FAIL coll_align got=%0d want<8", guard);
        end
        exp_s = m_steps();
        wr_en = 1'b1; wr_addr = BASE + 32'h8; wr_data = 32'(newp); wr_strb = 4'hF;
        rd_en = 1'b1; rd_addr = BASE + 32'hC;
        step();
        total++;
        if ({rd_valid, rd_data} !== {1'b1, exp_s}) begin
            bad++; $display("FAIL coll_rd_old got=%h want=%h", rd_data, exp_s);
        end
        rd(BASE + 32'hC, e);
        total++;
        if (rd_data !== exp_s) begin
            bad++; $display("FAIL coll_steps got=%h want=%h", rd_data, exp_s);
        end
        total++;
        if (vled_out !== pat) begin
            bad++; $display("FAIL coll_reload got=%h want=%h", vled_out, pat);
        end
        for (int j = 1; j <= newp + 1; j++) begin
            step();
            total++;
            if (vled_out !== (j <= newp ? pat : {pat[14:0], pat[15]})) begin
                bad++; $display("FAIL coll_restart[%0d] got=%h pat=%h", j, vled_out, pat);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        wr_en = 1'b1;
        wr_addr = BASE + 32'h4; wr_data = $urandom; wr_strb = 4'($urandom);
        step();
        wr_en = 1'b1;
        wr_addr = BASE + 32'h8; wr_data = $urandom_range(0, 3); wr_strb = 4'($urandom);
        step();
        wr_en = 1'b1;
        wr_addr = BASE; wr_data = {$urandom_range(0, 3), 1'b1}; wr_strb = 4'h1;
        step();
        for (int i = 0; i < 24; i++) begin
            step();
            total++;
            if (vled_out !== m_vled()) begin
                bad++; $display("FAIL b2b[%0d] got=%h want=%h", i, vled_out, m_vled());
            end
        end
        rd(BASE + 32'h4, e);
        total++;
        if (rd_data !== e) begin
            bad++; $display("FAIL b2b_pat got=%h want=%h", rd_data, e);
        end
        rd(BASE + 32'h8, e);
        total++;
        if (rd_data !== e) begin
            bad++; $display("FAIL b2b_per got=%h want=%h", rd_data, e);
        end
    endtask

    task automatic test_random();
        logic [31:0] addrs [6];
        logic [31:0] e;
        bit          did_rd;
        addrs = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC,
                  BASE + 32'h10, BASE - 32'h4};
        for (int i = 0; i < 200; i++) begin
            did_rd = 0;
            e      = '0;
            if ($urandom_range(0, 3) == 0) begin
                wr_en   = 1'b1;
                wr_addr = addrs[$urandom_range(0, 5)];
                wr_strb = 4'($urandom);
                wr_data = (wr_addr == BASE + 32'h8) ? $urandom_range(0, 3) : $urandom;
            end
            if ($urandom_range(0, 2) == 0) begin
                did_rd  = 1;
                rd_en   = 1'b1;
                rd_addr = addrs[$urandom_range(0, 5)];
                e       = m_reg(rd_addr);
            end
            step();
            total++;
            if ({rd_valid, rd_data} !== {did_rd, e}) begin
                bad++;
                $display("FAIL rnd_rd[%0d] got=%b/%h want=%b/%h", i, rd_valid, rd_data, did_rd, e);
            end
            if (!m_pending) begin
                total++;
                if (vled_out !== m_vled()) begin
                    bad++; $display("FAIL rnd_vled[%0d] got=%h want=%h", i, vled_out, m_vled());
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        wr(BASE + 32'h4, {16'h0, 16'(($urandom % 16'hFFFF) + 1)}, 4'hF);
        wr(BASE + 32'h8, 32'h0, 4'hF);
        wr(BASE, 32'h5, 4'h1);
        repeat (6) step();
        rd_en = 1'b1; rd_addr = BASE;
        step();
        #2;
        rst_main_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({vled_out, rd_valid, rd_data} !== 49'h0) begin
            bad++;
            $display("FAIL midrst_out got=%h/%b/%h want=0/0/0", vled_out, rd_valid, rd_data);
        end
        @(negedge clk_main_a0);
        rst_main_n = 1'b1;
        rd(BASE, e);
        total++;
        if ({rd_valid, rd_data} !== 33'h1_0000_0000) begin
            bad++; $display("FAIL midrst_ctrl got=%b/%h want=1/0", rd_valid, rd_data);
        end
        step();
        total++;
        if (vled_out !== 16'h0) begin
            bad++; $display("FAIL midrst_vled got=%h want=0000", vled_out);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_static();
        test_blink();
        test_rotate();
        test_pingpong();
        test_collision();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
